econet_tx_scheduler: RTL and testbench

Sequences frames into the buffered Econet transmitter from a small descriptor queue. Software pushes frame descriptors (start/end byte offsets in the shared 512-byte transmit buffer, plus an ack-required flag). The block programs the transmitter's frame-start and buffer-end registers and tracks the transmission through the transmitter's busy flag. It waits for the acknowledge frame with a timeout and retries with linear backoff, then reports a completion status per descriptor.

---
 rtl/econet_tx_scheduler_pkg.sv | 23 ++
 rtl/econet_tx_scheduler_if.sv | 38 +++
 rtl/econet_desc_fifo.sv | 50 +++++
 rtl/econet_tx_scheduler.sv | 159 +++++++++++++++
 tb/tb_econet_tx_scheduler.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/econet_tx_scheduler_pkg.sv
// econet_tx_scheduler_pkg: shared Econet transmit types.
// Holds the buffer offset width, the scheduler state encoding and the
// frame descriptor layout used by the queue and the sequencer.
package econet_tx_scheduler_pkg;
    localparam int ECO_CNTWIDTH = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_START,
        S_LOAD_END,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_WAIT_ACK,
        S_BACKOFF,
        S_REPORT
    } state_e;

    typedef struct packed {
        logic [ECO_CNTWIDTH-1:0] start_ofs;
        logic [ECO_CNTWIDTH-1:0] end_ofs;
        logic                    need_ack;
    } desc_t;
endpackage

// File: rtl/econet_tx_scheduler_if.sv
// econet_tx_scheduler_if: descriptor push, transmitter register port,
// transmitter status and completion report of the Econet tx scheduler.
//   master : host side (pushes descriptors, drives tx_busy / ack_seen)
//   slave  : scheduler side
interface econet_tx_scheduler_if
    import econet_tx_scheduler_pkg::*;
#(
    parameter int QDEPTH = 4
);
    logic                    desc_valid;
    logic                    desc_ready;
    logic [ECO_CNTWIDTH-1:0] desc_start;
    logic [ECO_CNTWIDTH-1:0] desc_end;
    logic                    desc_need_ack;
    logic [3:0]              tx_we;
    logic                    tx_select_frame_start;
    logic                    tx_select_buffer_end;
    logic [31:0]             tx_data;
    logic                    tx_busy;
    logic                    ack_seen;
    logic                    done_valid;
    logic                    done_ok;
    logic [1:0]              done_retries;
    logic [$clog2(QDEPTH):0] queue_count;
    logic                    idle;

    modport master (
        output desc_valid, desc_start, desc_end, desc_need_ack, tx_busy, ack_seen,
        input  desc_ready, tx_we, tx_select_frame_start, tx_select_buffer_end, tx_data,
               done_valid, done_ok, done_retries, queue_count, idle
    );

    modport slave (
        input  desc_valid, desc_start, desc_end, desc_need_ack, tx_busy, ack_seen,
        output desc_ready, tx_we, tx_select_frame_start, tx_select_buffer_end, tx_data,
               done_valid, done_ok, done_retries, queue_count, idle
    );
endinterface

// File: rtl/econet_desc_fifo.sv
// econet_desc_fifo: synchronous descriptor FIFO with occupancy count.
//   sys_clk, reset : clock, asynchronous active-high reset
//   push_i, din_i  : write request and descriptor (accepted when not full,
//                    or when full and a pop happens in the same cycle)
//   pop_i          : drop the head (ignored when empty)
//   head_o         : current head descriptor
//   full_o, empty_o, count_o : occupancy
module econet_desc_fifo
    import econet_tx_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  desc_t                  din_i,
    output desc_t                  head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    desc_t         mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign do_pop  = pop_i && count_q != '0;
    assign do_push = push_i && (count_q != (AW+1)'(DEPTH) || do_pop);
    assign head_o  = mem_q[rd_q];
    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;

    always_ff @(posedge sys_clk)
        if (do_push) mem_q[wr_q] <= din_i;

    always_ff @(posedge sys_clk or posedge reset)
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_q + AW'(do_push);
            rd_q    <= rd_q + AW'(do_pop);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/econet_tx_scheduler.sv
// econet_tx_scheduler: feeds queued frame descriptors to the buffered Econet
// transmitter, tracks busy, waits for acks with timeout and linear backoff,
// and reports one completion per descriptor.
//   sys_clk, reset : clock, asynchronous active-high reset
//   bus (slave)    : descriptor push, tx register writes, tx_busy/ack_seen,
//                    done report, queue_count, idle
module econet_tx_scheduler
    import econet_tx_scheduler_pkg::*;
#(
    parameter int QDEPTH       = 4,
    parameter int BUSY_TIMEOUT = 65535,
    parameter int ACK_TIMEOUT  = 65535,
    parameter int BACKOFF_UNIT = 1024,
    parameter int MAX_RETRY    = 3
) (
    input logic                  sys_clk,
    input logic                  reset,
    econet_tx_scheduler_if.slave bus
);
    state_e      state_q;
    desc_t       din, head;
    logic        full, empty;
    logic        busy_meta_q, busy_s_q;
    logic [31:0] timer_q;
    logic [1:0]  retries_q;
    logic [3:0]  we_q;
    logic        fs_q, be_q;
    logic [31:0] data_q;
    logic        done_valid_q, done_ok_q;
    logic [1:0]  done_retries_q;
    logic        popping;

    assign din     = '{start_ofs: bus.desc_start, end_ofs: bus.desc_end, need_ack: bus.desc_need_ack};
    assign popping = state_q == S_REPORT;

    econet_desc_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .sys_clk (sys_clk),
        .reset   (reset),
        .push_i  (bus.desc_valid && bus.desc_ready),
        .pop_i   (popping),
        .din_i   (din),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (bus.queue_count)
    );

    // A full queue still takes a push in the cycle the head is popped.
    assign bus.desc_ready            = !full || popping;
    assign bus.idle                  = empty && state_q == S_IDLE;
    assign bus.tx_we                 = we_q;
    assign bus.tx_select_frame_start = fs_q;
    assign bus.tx_select_buffer_end  = be_q;
    assign bus.tx_data               = data_q;
    assign bus.done_valid            = done_valid_q;
    assign bus.done_ok               = done_ok_q;
    assign bus.done_retries          = done_retries_q;

    always_ff @(posedge sys_clk or posedge reset)
        if (reset) begin
            busy_meta_q <= 1'b0;
            busy_s_q    <= 1'b0;
        end else begin
            busy_meta_q <= bus.tx_busy;
            busy_s_q    <= busy_meta_q;
        end

    // Timers are loaded with N-1 and expire on reaching 0, so a wait of N
    // cycles occupies its state for exactly N cycles.
    always_ff @(posedge sys_clk or posedge reset)
        if (reset) begin
            state_q        <= S_IDLE;
            timer_q        <= '0;
            retries_q      <= '0;
            we_q           <= '0;
            fs_q           <= 1'b0;
            be_q           <= 1'b0;
            data_q         <= '0;
            done_valid_q   <= 1'b0;
            done_ok_q      <= 1'b0;
            done_retries_q <= '0;
        end else begin
            we_q         <= '0;
            fs_q         <= 1'b0;
            be_q         <= 1'b0;
            data_q       <= '0;
            done_valid_q <= 1'b0;
            case (state_q)
                S_IDLE:
                    if (!empty) begin
                        state_q <= S_LOAD_START;
                        we_q    <= 4'hF;
                        fs_q    <= 1'b1;
                        data_q  <= 32'(head.start_ofs);
                    end
                S_LOAD_START: begin
                    state_q <= S_LOAD_END;
                    we_q    <= 4'hF;
                    be_q    <= 1'b1;
                    data_q  <= 32'(head.end_ofs);
                end
                S_LOAD_END: begin
                    state_q <= S_WAIT_BUSY;
                    timer_q <= 32'(BUSY_TIMEOUT - 1);
                end
                S_WAIT_BUSY:
                    if (busy_s_q) state_q <= S_WAIT_DONE;
                    else if (timer_q == '0) begin
                        state_q        <= S_REPORT;
                        done_valid_q   <= 1'b1;
                        done_ok_q      <= 1'b0;
                        done_retries_q <= retries_q;
                    end else timer_q <= timer_q - 32'd1;
                S_WAIT_DONE:
                    if (!busy_s_q) begin
                        if (head.need_ack) begin
                            state_q <= S_WAIT_ACK;
                            timer_q <= 32'(ACK_TIMEOUT - 1);
                        end else begin
                            state_q        <= S_REPORT;
                            done_valid_q   <= 1'b1;
                            done_ok_q      <= 1'b1;
                            done_retries_q <= retries_q;
                        end
                    end
                S_WAIT_ACK:
                    // Ack takes priority over a coincident timeout.
                    if (bus.ack_seen) begin
                        state_q        <= S_REPORT;
                        done_valid_q   <= 1'b1;
                        done_ok_q      <= 1'b1;
                        done_retries_q <= retries_q;
                    end else if (timer_q == '0) begin
                        if (32'(retries_q) < 32'(MAX_RETRY)) begin
                            state_q   <= S_BACKOFF;
                            retries_q <= retries_q + 2'd1;
                            timer_q   <= (32'(retries_q) + 32'd1) * 32'(BACKOFF_UNIT) - 32'd1;
                        end else begin
                            state_q        <= S_REPORT;
                            done_valid_q   <= 1'b1;
                            done_ok_q      <= 1'b0;
                            done_retries_q <= retries_q;
                        end
                    end else timer_q <= timer_q - 32'd1;
                S_BACKOFF:
                    if (timer_q == '0) begin
                        state_q <= S_LOAD_START;
                        we_q    <= 4'hF;
                        fs_q    <= 1'b1;
                        data_q  <= 32'(head.start_ofs);
                    end else timer_q <= timer_q - 32'd1;
                S_REPORT: begin
                    state_q   <= S_IDLE;
                    retries_q <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
endmodule

// File: tb/tb_econet_tx_scheduler.sv
// tb_econet_tx_scheduler: directed and randomized checks of the Econet
// transmit scheduler against a timing/outcome model of the transmitter.
module tb_econet_tx_scheduler;
    localparam int QD = 4, BT = 40, AT = 30, BU = 16, MR = 3;
    // A tx_busy edge is acted on by the FSM three cycles after it is driven
    // (two synchroniser flops, then the FSM sampling busy_s).
    localparam int SYNC = 3;

    logic sys_clk = 1'b0;
    logic reset   = 1'b1;
    int   cyc     = 0;
    int   passed  = 0, failed = 0, total = 0;

    econet_tx_scheduler_if #(.QDEPTH(QD)) bus ();

    econet_tx_scheduler #(
        .QDEPTH(QD), .BUSY_TIMEOUT(BT), .ACK_TIMEOUT(AT), .BACKOFF_UNIT(BU), .MAX_RETRY(MR)
    ) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {int cyc; logic fs; logic be; logic [31:0] data;} wr_t;
    typedef struct {int cyc; logic ok; logic [1:0] rt;} dn_t;
    wr_t wrs[$];
    dn_t dns[$];
    int  falls[$];

    // Transmitter / receive-path model: busy rises busy_lat cycles after each
    // buffer-end write and lasts busy_len cycles; attempt k's ack (if any) is
    // pulsed ack_plan[k] cycles after busy falls.
    bit busy_en = 1'b0;
    int busy_lat = 2, busy_len = 1;
    int ack_plan[4] = '{-1, -1, -1, -1};
    int attempt = 0;
    int busy_from = -1, busy_until = -1, ack_at = -1;

    always @(negedge sys_clk) begin
        if (!reset) begin
            if (bus.tx_we != 4'h0)
                wrs.push_back('{cyc, bus.tx_select_frame_start, bus.tx_select_buffer_end, bus.tx_data});
            if (bus.done_valid)
                dns.push_back('{cyc, bus.done_ok, bus.done_retries});
            if (bus.tx_we != 4'h0 && bus.tx_select_buffer_end) begin
                attempt++;
                if (busy_en) begin
                    busy_from  = cyc + busy_lat;
                    busy_until = busy_from + busy_len;
                end
            end
        end
        bus.tx_busy = cyc >= busy_from && cyc < busy_until;
        if (cyc == busy_until) begin
            falls.push_back(cyc);
            ack_at = -1;
            if (attempt >= 1 && attempt <= 4)
                if (ack_plan[attempt-1] >= 0) ack_at = cyc + ack_plan[attempt-1];
        end
        bus.ack_seen = cyc == ack_at;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge sys_clk);
            #1;
        end
    endtask

    task automatic push(input logic [8:0] s, input logic [8:0] e, input logic a);
        bus.desc_valid    = 1'b1;
        bus.desc_start    = s;
        bus.desc_end      = e;
        bus.desc_need_ack = a;
        tick();
        bus.desc_valid    = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " tx_we"}, 32'(bus.tx_we), 0);
        check({tag, " sel_fs"}, 32'(bus.tx_select_frame_start), 0);
        check({tag, " sel_be"}, 32'(bus.tx_select_buffer_end), 0);
        check({tag, " tx_data"}, bus.tx_data, 0);
        check({tag, " done_valid"}, 32'(bus.done_valid), 0);
        check({tag, " done_ok"}, 32'(bus.done_ok), 0);
        check({tag, " done_retries"}, 32'(bus.done_retries), 0);
        check({tag, " queue_count"}, 32'(bus.queue_count), 0);
        check({tag, " desc_ready"}, 32'(bus.desc_ready), 1);
        check({tag, " idle"}, 32'(bus.idle), 1);
    endtask

    task automatic wait_done(input int n0, input int budget, input string tag);
        int i = 0;
        while (dns.size() <= n0 && i < budget) begin
            tick();
            i++;
        end
        check({tag, " done_seen"}, 32'(dns.size() > n0), 1);
    endtask

    task automatic scenario(input string tag, input logic need_ack, input bit ben, input int blen,
                            input int a0, input int a1, input int a2, input int a3);
        logic [8:0] s, e;
        int pc, n0, att, rt;
        logic ok;
        s = 9'($urandom);
        e = 9'($urandom);
        busy_en = ben; busy_len = blen; ack_plan = '{a0, a1, a2, a3};
        attempt = 0; ack_at = -1; busy_from = -1; busy_until = -1;
        wrs.delete(); falls.delete();
        n0 = dns.size();
        // Outcome model: an ack counts only if it lands in the ACK_TIMEOUT
        // window that opens once the falling busy edge has been seen.
        att = 1;
        ok  = ben;
        if (ben && need_ack) begin
            ok  = 1'b0;
            att = MR + 1;
            for (int k = 0; k <= MR; k++)
                if (!ok && ack_plan[k] >= SYNC && ack_plan[k] < SYNC + AT) begin
                    ok  = 1'b1;
                    att = k + 1;
                end
        end
        rt = att - 1;
        pc = cyc;
        push(s, e, need_ack);
        wait_done(n0, 3000, tag);
        check($sformatf("%s writes", tag), 32'(wrs.size()), 32'(2 * att));
        if (wrs.size() > 0) check($sformatf("%s start_latency", tag), 32'(wrs[0].cyc - pc), 2);
        for (int k = 0; k < att && wrs.size() >= 2 * k + 2; k++) begin
            check($sformatf("%s a%0d fs_sel", tag, k), 32'({wrs[2*k].fs, wrs[2*k].be}), 32'h2);
            check($sformatf("%s a%0d fs_data", tag, k), wrs[2*k].data, 32'(s));
            check($sformatf("%s a%0d be_sel", tag, k), 32'({wrs[2*k+1].fs, wrs[2*k+1].be}), 32'h1);
            check($sformatf("%s a%0d be_data", tag, k), wrs[2*k+1].data, 32'(e));
            check($sformatf("%s a%0d be_follows", tag, k), 32'(wrs[2*k+1].cyc - wrs[2*k].cyc), 1);
            if (k > 0 && falls.size() >= k)
                check($sformatf("%s a%0d backoff_gap", tag, k), 32'(wrs[2*k].cyc - falls[k-1]),
                      32'(SYNC + AT + k * BU));
        end
        if (dns.size() > n0) begin
            check($sformatf("%s done_ok", tag), 32'(dns[n0].ok), 32'(ok));
            check($sformatf("%s done_retries", tag), 32'(dns[n0].rt), 32'(rt));
            if (!ben && wrs.size() >= 2)
                check($sformatf("%s busy_timeout", tag), 32'(dns[n0].cyc - wrs[1].cyc), 32'(BT + 1));
        end
        tick(2);
        check($sformatf("%s idle_after", tag), 32'(bus.idle), 1);
    endtask

    initial begin
        logic [8:0] fs_exp[5];
        logic [8:0] ds[6];
        int n0, i, nfs;
        bus.desc_valid = 1'b0;
        bus.desc_start = '0;
        bus.desc_end = '0;
        bus.desc_need_ack = 1'b0;
        tick(3);
        check_reset_state("reset");
        reset = 1'b0;
        tick(2);

        scenario("plain", 1'b0, 1'b1, 20, -1, -1, -1, -1);
        scenario("ack5", 1'b1, 1'b1, 20, 5, -1, -1, -1);
        scenario("ack_coincident", 1'b1, 1'b1, 12, SYNC + AT - 1, -1, -1, -1);
        scenario("ack_late", 1'b1, 1'b1, 12, SYNC + AT, 5, -1, -1);
        scenario("ack_early_ignored", 1'b1, 1'b1, 8, SYNC - 1, SYNC, -1, -1);
        scenario("no_ack", 1'b1, 1'b1, 10, -1, -1, -1, -1);
        scenario("no_busy", 1'b0, 1'b0, 10, -1, -1, -1, -1);
        for (int r = 0; r < 6; r++) begin
            int p[4];
            for (int k = 0; k < 4; k++)
                p[k] = $urandom_range(0, 3) == 0 ? -1 : int'($urandom_range(0, SYNC + AT + 4));
            scenario($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0,
                     int'($urandom_range(1, 25)), p[0], p[1], p[2], p[3]);
        end

        // Queue fill: 4 accepted, 5th dropped, 6th accepted during a pop.
        busy_en = 1'b1; busy_len = 3; ack_plan = '{-1, -1, -1, -1};
        attempt = 0; ack_at = -1; busy_from = -1; busy_until = -1;
        wrs.delete(); falls.delete();
        n0 = dns.size();
        for (int k = 0; k < 6; k++) ds[k] = 9'($urandom);
        for (int k = 0; k < 5; k++) begin
            push(ds[k], ~ds[k], 1'b0);
            if (k == 2) check("fifo count3", 32'(bus.queue_count), 3);
            if (k == 2) check("fifo ready3", 32'(bus.desc_ready), 1);
            if (k == 3) check("fifo ready_full", 32'(bus.desc_ready), 0);
            if (k >= 3) check($sformatf("fifo count_full%0d", k), 32'(bus.queue_count), 4);
        end
        i = 0;
        while (!bus.done_valid && i < 500) begin
            tick();
            i++;
        end
        check("fifo pop_seen", 32'(bus.done_valid), 1);
        check("fifo pop_count", 32'(bus.queue_count), 4);
        check("fifo pop_ready", 32'(bus.desc_ready), 1);
        push(ds[5], ~ds[5], 1'b0);
        check("fifo push_pop_count", 32'(bus.queue_count), 4);
        i = 0;
        while (dns.size() < n0 + 5 && i < 1000) begin
            tick();
            i++;
        end
        tick(5);
        check("fifo dones", 32'(dns.size() - n0), 5);
        fs_exp = '{ds[0], ds[1], ds[2], ds[3], ds[5]};
        nfs = 0;
        foreach (wrs[j])
            if (wrs[j].fs) begin
                if (nfs < 5) check($sformatf("fifo order%0d", nfs), wrs[j].data, 32'(fs_exp[nfs]));
                nfs++;
            end
        check("fifo frames", 32'(nfs), 5);
        check("fifo empty", 32'(bus.queue_count), 0);

        // Reset while the frame is on the wire.
        busy_en = 1'b1; busy_len = 60; ack_plan = '{-1, -1, -1, -1};
        attempt = 0; ack_at = -1; busy_from = -1; busy_until = -1;
        push(9'h010, 9'h03F, 1'b1);
        i = 0;
        while (!(bus.tx_busy && cyc >= busy_from + 6) && i < 200) begin
            tick();
            i++;
        end
        check("rst busy_reached", 32'(bus.tx_busy), 1);
        reset = 1'b1;
        #1;
        check_reset_state("rst_mid");
        busy_from = -1; busy_until = -1; ack_at = -1;
        tick(2);
        reset = 1'b0;
        n0 = dns.size();
        tick(100);
        check("rst no_done", 32'(dns.size() - n0), 0);
        check("rst idle", 32'(bus.idle), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
